// File: rtl/fetch_pkg.sv
// fetch_pkg: types and constants shared by the instruction fetch stage.
//   fetch_state_t : fetch FSM state encoding
//   fetch_entry_t : one buffered fetch {pc, instr}
//   fcnt_t        : occupancy / in-flight counter width (0..FETCH_DEPTH)
package fetch_pkg;

   typedef enum logic [1:0] {
      FS_IDLE,
      FS_RUN,
      FS_FLUSH
   } fetch_state_t;

   localparam int unsigned FETCH_DEPTH = 2;
   localparam int unsigned INSTR_BYTES = 4;

   typedef logic [1:0] fcnt_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_if.sv
// fetch_if: instruction memory request/response bus.
//   imem_req_valid / imem_req_addr / imem_req_ready : request handshake
//   imem_rsp_valid / imem_rsp_data                  : in-order responses
//   master : fetch unit side, slave : memory side
interface fetch_if;

   logic        imem_req_valid;
   logic [31:0] imem_req_addr;
   logic        imem_req_ready;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;

   modport master (
      output imem_req_valid,
      output imem_req_addr,
      input  imem_req_ready,
      input  imem_rsp_valid,
      input  imem_rsp_data
   );

   modport slave (
      input  imem_req_valid,
      input  imem_req_addr,
      output imem_req_ready,
      output imem_rsp_valid,
      output imem_rsp_data
   );

endinterface

// File: rtl/fetch_buffer.sv
// fetch_buffer: 2-entry FIFO of fetched {pc, instr}, entry 0 is the head.
//   clk, reset : clock, asynchronous active-high reset
//   push, din  : write one entry (ignored when full after this cycle's pop)
//   pop        : drop the head entry
//   clear      : empty the FIFO; overrides push and pop
//   head       : current head entry (registered)
//   count      : number of valid entries
module fetch_buffer
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
)
(
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  logic         pop,
   input  logic         clear,
   input  fetch_entry_t din,
   output fetch_entry_t head,
   output fcnt_t        count
);

   fetch_entry_t [FETCH_DEPTH-1:0] ent, ent_n;
   fcnt_t                          cnt_pop, cnt_n;

   // Pop shifts the array down first; the push slot is then the
   // post-pop occupancy, so push and pop may coincide on a full FIFO.
   always_comb begin
      ent_n   = ent;
      cnt_pop = count;
      cnt_n   = count;
      if (clear) begin
         cnt_n = '0;
      end else begin
         if (pop && (count != '0)) begin
            ent_n[0] = ent[1];
            cnt_pop  = count - 2'd1;
         end
         cnt_n = cnt_pop;
         if (push && (cnt_pop < fcnt_t'(FETCH_DEPTH))) begin
            ent_n[cnt_pop[0]] = din;
            cnt_n             = cnt_pop + 2'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < FETCH_DEPTH; i++) begin
            ent[i] <= '{pc: RESET_PC, instr: '0};
         end
         count <= '0;
      end else begin
         ent   <= ent_n;
         count <= cnt_n;
      end
   end

   assign head = ent[0];

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage for the ARM-subset core.
//   clk, reset : clock, asynchronous active-high reset
//   mem        : instruction memory bus (fetch_if.master)
//   Instr, PC  : head instruction and its address
//   PCPlus8    : PC + 8 (R15 read value)
//   InstrValid : Instr/PC valid
//   stall      : downstream not consuming this cycle
//   PCSrc      : redirect request, honoured only when InstrValid && !stall
//   Result     : redirect target, low two bits ignored
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
)
(
   input  logic           clk,
   input  logic           reset,
   fetch_if.master        mem,
   output logic [31:0]    Instr,
   output logic [31:0]    PC,
   output logic [31:0]    PCPlus8,
   output logic           InstrValid,
   input  logic           stall,
   input  logic           PCSrc,
   input  logic [31:0]    Result
);

   fetch_state_t     state, state_n;
   logic [31:0]      fpc;
   fcnt_t            outstanding, out_n;
   fcnt_t            discard, discard_n;
   fcnt_t            count;
   logic [1:0][31:0] aq, aq_n;
   fetch_entry_t     head, din;

   logic       consume, redirect, rsp, accept, drop, push, credit, req_valid;
   logic       wr_slot;
   logic [2:0] load;

   assign InstrValid = (count != '0);
   assign consume    = InstrValid && !stall;
   assign redirect   = consume && PCSrc;

   // The entry popped this cycle frees its slot immediately, which keeps
   // a zero-wait memory at one instruction per cycle.
   assign load   = {1'b0, count - fcnt_t'(consume)} + {1'b0, outstanding};
   assign credit = (load < 3'd2);

   assign accept = req_valid && mem.imem_req_ready;
   // Responses with nothing in flight (e.g. after a reset) are ignored.
   assign rsp    = mem.imem_rsp_valid && (outstanding != '0);
   assign drop   = rsp && ((discard != '0) || redirect);
   assign push   = rsp && !drop;
   assign out_n  = outstanding + fcnt_t'(accept) - fcnt_t'(rsp);

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= FS_IDLE;
      end else begin
         state <= state_n;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_n = state;
      unique case (state)
         FS_IDLE:  state_n = FS_RUN;
         FS_RUN:   if (redirect && (out_n != '0)) state_n = FS_FLUSH;
         FS_FLUSH: if (discard_n == '0) state_n = FS_RUN;
         default:  state_n = FS_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      req_valid = 1'b0;
      unique case (state)
         FS_RUN:  req_valid = credit;
         default: req_valid = 1'b0;
      endcase
   end

   // Stale in-flight count: every in-flight fetch at a redirect, including
   // one accepted in that cycle, must be dropped when it returns.
   always_comb begin
      discard_n = discard;
      if (redirect) begin
         discard_n = out_n;
      end else if (rsp && (discard != '0)) begin
         discard_n = discard - 2'd1;
      end
   end

   // In-flight address queue, one slot per outstanding request. It is not
   // cleared on redirect; stale addresses drain with their dropped responses.
   assign wr_slot = (outstanding == 2'd1) && !rsp;

   always_comb begin
      aq_n = aq;
      if (rsp) begin
         aq_n[0] = aq[1];
      end
      if (accept) begin
         aq_n[wr_slot] = fpc;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fpc         <= RESET_PC;
         outstanding <= '0;
         discard     <= '0;
         aq          <= '0;
      end else begin
         outstanding <= out_n;
         discard     <= discard_n;
         aq          <= aq_n;
         if (redirect) begin
            fpc <= Result & ~32'h0000_0003;
         end else if (accept) begin
            fpc <= fpc + 32'(INSTR_BYTES);
         end
      end
   end

   assign din = '{pc: aq[0], instr: mem.imem_rsp_data};

   fetch_buffer #(
      .RESET_PC (RESET_PC)
   ) u_buf (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (consume && !redirect),
      .clear (redirect),
      .din   (din),
      .head  (head),
      .count (count)
   );

   assign mem.imem_req_valid = req_valid;
   assign mem.imem_req_addr  = fpc;

   assign Instr   = head.instr;
   assign PC      = head.pc;
   assign PCPlus8 = head.pc + 32'(2 * INSTR_BYTES);

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit with a latency-configurable
// in-order instruction memory model.
module tb_fetch_unit;

   logic        clk    = 1'b0;
   logic        reset  = 1'b0;
   logic        stall  = 1'b0;
   logic        PCSrc  = 1'b0;
   logic [31:0] Result = '0;
   logic [31:0] Instr, PC, PCPlus8;
   logic        InstrValid;

   int unsigned mem_lat  = 1;
   int          checks   = 0;
   int          failures = 0;
   logic [31:0] exp_pc;
   int          delivered;

   fetch_if mem_if ();

   fetch_unit #(
      .RESET_PC (32'h0000_0100)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .mem        (mem_if),
      .Instr      (Instr),
      .PC         (PC),
      .PCPlus8    (PCPlus8),
      .InstrValid (InstrValid),
      .stall      (stall),
      .PCSrc      (PCSrc),
      .Result     (Result)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] word_at(input logic [31:0] a);
      return a ^ 32'h5A5A_0000;
   endfunction

   // Memory: request accepted in cycle c is answered in cycle c + mem_lat.
   typedef struct packed {
      logic [31:0] addr;
      int unsigned due;
   } mreq_t;

   mreq_t       mq[$];
   int unsigned cyc = 0;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         mq.delete();
         cyc = 0;
         mem_if.imem_rsp_valid <= 1'b0;
         mem_if.imem_rsp_data  <= '0;
      end else begin
         if (mem_if.imem_req_valid && mem_if.imem_req_ready) begin
            mq.push_back('{addr: mem_if.imem_req_addr, due: cyc + mem_lat});
         end
         cyc = cyc + 1;
         if ((mq.size() > 0) && (mq[0].due == cyc)) begin
            mem_if.imem_rsp_valid <= 1'b1;
            mem_if.imem_rsp_data  <= word_at(mq[0].addr);
            mq.pop_front();
         end else begin
            mem_if.imem_rsp_valid <= 1'b0;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s: observed %08h expected %08h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_reqv"},  32'(mem_if.imem_req_valid), 32'd0);
      chk({tag, "_addr"},  mem_if.imem_req_addr, 32'h0000_0100);
      chk({tag, "_instr"}, Instr, 32'h0);
      chk({tag, "_pc"},    PC, 32'h0000_0100);
      chk({tag, "_pc8"},   PCPlus8, 32'h0000_0108);
      chk({tag, "_ivld"},  32'(InstrValid), 32'd0);
   endtask

   task automatic chk_head(input string tag, input logic [31:0] pc);
      chk({tag, "_ivld"},  32'(InstrValid), 32'd1);
      chk({tag, "_pc"},    PC, pc);
      chk({tag, "_instr"}, Instr, word_at(pc));
      chk({tag, "_pc8"},   PCPlus8, pc + 32'd8);
   endtask

   task automatic chk_req(input string tag, input logic v, input logic [31:0] a);
      chk({tag, "_reqv"}, 32'(mem_if.imem_req_valid), 32'(v));
      if (v) chk({tag, "_addr"}, mem_if.imem_req_addr, a);
   endtask

   initial begin
      mem_if.imem_req_ready = 1'b1;

      // ---- reset, zero-wait memory ----
      #1 reset = 1'b1;
      tick();
      tick();
      chk_reset("rst");
      reset = 1'b0;                              // cycle R0 (IDLE)
      #1 chk_req("idle", 1'b0, 32'h0);
      tick(); #1 chk_req("r1", 1'b1, 32'h0000_0100);
      tick(); #1 chk_req("r2", 1'b1, 32'h0000_0104);
      chk("r2_ivld", 32'(InstrValid), 32'd0);
      tick();
      exp_pc = 32'h0000_0100;
      for (int i = 0; i < 6; i++) begin
         #1 chk_head("steady", exp_pc);
         chk_req("steady", 1'b1, exp_pc + 32'd8);
         exp_pc += 32'd4;
         tick();
      end

      // ---- stall 5 cycles with full buffer ----
      stall = 1'b1;
      #1 chk_req("stall", 1'b0, 32'h0);
      chk_head("stall", exp_pc);
      for (int i = 0; i < 4; i++) begin
         tick();
         #1 chk_req("stall", 1'b0, 32'h0);
         chk_head("stall", exp_pc);
      end
      tick();
      stall = 1'b0;
      #1 chk_head("release", exp_pc);
      chk_req("release", 1'b1, exp_pc + 32'd8);
      tick();
      exp_pc += 32'd4;
      stall = 1'b1;
      #1 chk_head("release_pop", exp_pc);

      // ---- redirect with nothing in flight (request refused) ----
      tick();
      tick();
      stall  = 1'b0;
      PCSrc  = 1'b1;
      Result = 32'h0000_4000;
      mem_if.imem_req_ready = 1'b0;
      #1 chk_head("redir0", exp_pc);
      chk_req("redir0", 1'b1, exp_pc + 32'd8);
      tick();
      PCSrc = 1'b0;
      mem_if.imem_req_ready = 1'b1;
      #1 chk_req("redir0_t1", 1'b1, 32'h0000_4000);
      chk("redir0_t1_ivld", 32'(InstrValid), 32'd0);
      tick(); #1 chk("redir0_t2_ivld", 32'(InstrValid), 32'd0);
      tick();

      // ---- redirect with response and accept in the same cycle ----
      PCSrc  = 1'b1;
      Result = 32'hFFFF_FFFB;
      #1 chk_head("redir1", 32'h0000_4000);
      chk_req("redir1", 1'b1, 32'h0000_4008);
      tick();
      PCSrc = 1'b0;
      #1 chk_req("flush1", 1'b0, 32'h0);
      chk("flush1_ivld", 32'(InstrValid), 32'd0);
      tick(); #1 chk_req("wrap_t2", 1'b1, 32'hFFFF_FFF8);
      chk("wrap_t2_ivld", 32'(InstrValid), 32'd0);
      tick(); #1 chk_req("wrap_t3", 1'b1, 32'hFFFF_FFFC);
      chk("wrap_t3_ivld", 32'(InstrValid), 32'd0);
      tick(); #1 chk_req("wrap_t4", 1'b1, 32'h0000_0000);
      exp_pc = 32'hFFFF_FFF8;
      for (int i = 0; i < 3; i++) begin
         chk_head("wrap", exp_pc);
         exp_pc += 32'd4;
         tick();
         #1;
      end

      // ---- async reset mid-run, then 3-cycle memory and flush ----
      mem_lat = 3;
      reset = 1'b1;
      #1 chk_reset("rst_run");
      tick();
      reset = 1'b0;                              // R0
      #1 chk_req("l3_r0", 1'b0, 32'h0);
      tick(); #1 chk_req("l3_r1", 1'b1, 32'h0000_0100);
      tick(); #1 chk_req("l3_r2", 1'b1, 32'h0000_0104);
      tick(); #1 chk_req("l3_r3", 1'b0, 32'h0);
      tick(); #1 chk_req("l3_r4", 1'b0, 32'h0);
      chk("l3_r4_ivld", 32'(InstrValid), 32'd0);
      tick(); #1 chk_head("l3_r5", 32'h0000_0100);
      chk_req("l3_r5", 1'b1, 32'h0000_0108);
      tick();
      PCSrc  = 1'b1;
      Result = 32'h0000_2003;
      #1 chk_head("l3_r6", 32'h0000_0104);
      chk_req("l3_r6", 1'b1, 32'h0000_010C);
      tick();
      PCSrc = 1'b0;
      for (int i = 7; i <= 9; i++) begin
         #1 chk_req("l3_flush", 1'b0, 32'h0);
         chk("l3_flush_ivld", 32'(InstrValid), 32'd0);
         tick();
      end
      #1 chk_req("l3_r10", 1'b1, 32'h0000_2000);
      tick(); #1 chk_req("l3_r11", 1'b1, 32'h0000_2004);
      tick(); #1 chk_req("l3_r12", 1'b0, 32'h0);
      chk("l3_r12_ivld", 32'(InstrValid), 32'd0);
      tick(); #1 chk("l3_r13_ivld", 32'(InstrValid), 32'd0);
      tick(); #1 chk_head("l3_r14", 32'h0000_2000);

      // ---- async reset while flushing ----
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int i = 0; i < 6; i++) tick();       // R6
      PCSrc  = 1'b1;
      Result = 32'h0000_2003;
      tick();
      PCSrc = 1'b0;
      tick();                                    // R8, in FLUSH
      reset = 1'b1;
      #1 chk_reset("rst_flush");

      // ---- free run, 3-cycle memory, in-order delivery ----
      tick();
      reset = 1'b0;
      exp_pc    = 32'h0000_0100;
      delivered = 0;
      for (int i = 0; i < 40; i++) begin
         #1;
         if (InstrValid) begin
            chk("run_pc", PC, exp_pc);
            chk("run_instr", Instr, word_at(exp_pc));
            exp_pc += 32'd4;
            delivered++;
         end
         chk("run_outst_le2",
             32'((mq.size() + 32'(mem_if.imem_rsp_valid)) <= 32'd2), 32'd1);
         tick();
      end
      chk("run_delivered", 32'(delivered >= 16), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
